// File: rtl/shift_add_mult.sv
// ============================================================================
// Module   : shift_add_mult
// Purpose  : Sequential unsigned N x N shift-and-add multiplier (IDLE/BUSY/DONE).
//            Optional early exit when the remaining multiplier bits are zero:
//            define SHIFT_ADD_MULT_SKIP_ZERO_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_add_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int SW = $clog2(N + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [SW-1:0]    step_q, step_d;
    logic [2*N-1:0]   p_q, p_d;

    logic [2*N-1:0]   acc_sum;
    logic [N-1:0]     mplier_shr;
    logic             finish;

    assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
    assign mplier_shr = mplier_q >> 1;

`ifdef SHIFT_ADD_MULT_SKIP_ZERO_EN
    // Once no set multiplier bits remain, further steps cannot change acc.
    assign finish = (step_q == LAST_STEP) || (mplier_shr == {N{1'b0}});
`else
    assign finish = (step_q == LAST_STEP);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        step_d   = step_q;
        p_d      = p_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = {{N{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = {(2*N){1'b0}};
                    step_d   = {SW{1'b0}};
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                step_d   = step_q + 1'b1;
                if (finish) begin
                    p_d     = acc_sum;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= {(2*N){1'b0}};
            mcand_q  <= {(2*N){1'b0}};
            mplier_q <= {N{1'b0}};
            step_q   <= {SW{1'b0}};
            p_q      <= {(2*N){1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            step_q   <= step_d;
            p_q      <= p_d;
        end
    end

    assign ready = (state_q != BUSY);
    assign done  = (state_q == DONE);
    assign P     = p_q;

endmodule

`default_nettype wire

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only while ready=1.
REQ-005 SHALL have port A  input  N  unsigned multiplicand; sampled on the accepting edge only.
REQ-006 SHALL have port B  input  N  unsigned multiplier; sampled on the accepting edge only.
REQ-007 SHALL have port ready  output  1  high when a new start will be accepted (states IDLE and DONE).
REQ-008 SHALL have port done  output  1  high while P holds a completed, valid product.
REQ-009 SHALL have port P  output  2N  registered unsigned product A*B.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-011 SHALL accept a request on a rising edge where start=1 and ready=1: mcand<=zero-extended A (2N bits), mplier<=B, acc<=0, step<=0, state<=BUSY.
REQ-012 SHALL, in BUSY, per cycle: if mplier[0]=1 then acc<=acc+mcand (2N-bit add, no overflow possible); mcand<=mcand<<1; mplier<=mplier>>1; step<=step+1.
REQ-013 SHALL leave BUSY for DONE on the edge completing step N (macro off), loading P with the final acc value on that same edge.
REQ-014 SHALL hold done=1 and ready=1 throughout DONE; P SHALL remain stable until the next completion.
REQ-015 SHALL drop done to 0 on the edge that accepts a new start from DONE; P SHALL retain the old product until the new result is loaded.
REQ-016 SHALL ignore start, A and B while in BUSY; the operation in progress is not disturbed.
REQ-017 SHALL, with macro off, have fixed latency: start accepted at edge k -> done=1 and P valid after edge k+N.
REQ-018 SHALL produce correct results for boundary operands: A=0 or B=0 -> P=0; A=B=2^N-1 -> P=(2^N-1)^2.
REQ-019 SHALL keep ready=0 and done=0 in BUSY; done SHALL never be 1 while ready=0.
REQ-020 SHALL remain in IDLE (ready=1, done=0) when start=0.

Reset
REQ-021 SHALL, on rst_n=0 (asynchronous, any state including mid-BUSY), force state=IDLE, P=0, done=0, ready=1, acc/mcand/mplier/step=0.
REQ-022 SHALL discard any operation interrupted by reset; no partial product appears on P.
REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL support macro SHIFT_ADD_MULT_SKIP_ZERO_EN.
REQ-025 SHALL, when SHIFT_ADD_MULT_SKIP_ZERO_EN is defined, also leave BUSY for DONE on any edge where the post-shift mplier value equals 0, loading P with the updated acc; latency = 1 + index of B's highest set bit (minimum 1 cycle, B=0 -> 1 cycle).
REQ-026 SHALL, when SHIFT_ADD_MULT_SKIP_ZERO_EN is undefined, always take exactly N BUSY cycles; products SHALL be identical in both builds.

Verification (N=4)
REQ-027 SHALL cover: reset, A=12, B=5, start one cycle -> after 4 edges done=1, P=60, ready=1.
REQ-028 SHALL cover: A=15, B=15 -> P=225; then A=0, B=9 -> P=0; done low during second BUSY, P=225 held until reload.
REQ-029 SHALL cover: A=7, B=2 accepted, then start=1 with A=3, B=3 during BUSY -> P=14, second request ignored, FSM returns to DONE once.
REQ-030 SHALL cover: A=9, B=11 accepted, rst_n=0 after 2 edges -> P=0, done=0, ready=1 immediately; subsequent A=9, B=11 -> P=99.
REQ-031 SHALL cover macro on: A=13, B=1 -> done after 1 edge, P=13; A=6, B=0 -> 1 edge, P=0; A=5, B=8 -> 4 edges, P=40.
REQ-032 SHALL cover: exhaustive sweep of all 256 A,B pairs, both builds, each P checked against A*B.
